// File: rtl/laser_pulse_ctrl.sv
// rtl/laser_pulse_ctrl.sv - laser pulse controller with cool-down lockout, repeat and abort
// Optional burst mode (BurstCnt port, pulses per trigger) enabled by defining LASER_BURST_EN.
module laser_pulse_ctrl #(
   parameter int CNT_W   = 16,
   parameter int BURST_W = 4
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               B,
   input  logic               Abort,
   input  logic               Mode,
   input  logic [CNT_W-1:0]   OnTime,
   input  logic [CNT_W-1:0]   OffTime,
`ifdef LASER_BURST_EN
   input  logic [BURST_W-1:0] BurstCnt,
`endif
   output logic               X,
   output logic               Busy,
   output logic               Done,
   output logic [CNT_W-1:0]   Remaining
);

   typedef enum logic [1:0] {IDLE, ON, COOL} state_t;

   state_t               state, state_n;
   logic                 bq;
   logic [CNT_W-1:0]     on_lat, on_lat_n, off_lat, off_lat_n;
   logic [BURST_W-1:0]   pulse_cnt, pulse_n;
   logic                 x_n, busy_n, done_n;
   logic [CNT_W-1:0]     rem_n;
   logic                 start, last_pulse, more_pulses;

   assign start = B && !bq;
   // A non-zero pulse count means a burst is still in progress.
   assign more_pulses = (pulse_cnt != '0);

`ifdef LASER_BURST_EN
   logic [BURST_W-1:0] burst_lat, burst_lat_n;
   assign last_pulse = (pulse_cnt == burst_lat - BURST_W'(1));
`else
   assign last_pulse = 1'b1;
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         X         <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Remaining <= '0;
         bq        <= 1'b0;
         on_lat    <= '0;
         off_lat   <= '0;
         pulse_cnt <= '0;
`ifdef LASER_BURST_EN
         burst_lat <= '0;
`endif
      end else begin
         state     <= state_n;
         X         <= x_n;
         Busy      <= busy_n;
         Done      <= done_n;
         Remaining <= rem_n;
         bq        <= B;
         on_lat    <= on_lat_n;
         off_lat   <= off_lat_n;
         pulse_cnt <= pulse_n;
`ifdef LASER_BURST_EN
         burst_lat <= burst_lat_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      x_n       = X;
      busy_n    = Busy;
      done_n    = 1'b0;
      rem_n     = Remaining;
      on_lat_n  = on_lat;
      off_lat_n = off_lat;
      pulse_n   = pulse_cnt;
`ifdef LASER_BURST_EN
      burst_lat_n = burst_lat;
`endif
      case (state)
         IDLE: begin
            x_n    = 1'b0;
            busy_n = 1'b0;
            rem_n  = '0;
            if (start && !Abort) begin
               state_n   = ON;
               x_n       = 1'b1;
               busy_n    = 1'b1;
               on_lat_n  = (OnTime == '0) ? CNT_W'(1) : OnTime;
               off_lat_n = OffTime;
               rem_n     = on_lat_n;
               pulse_n   = '0;
`ifdef LASER_BURST_EN
               burst_lat_n = (BurstCnt == '0) ? BURST_W'(1) : BurstCnt;
`endif
            end
         end
         ON: begin
            if (Abort) begin
               state_n = IDLE;
               x_n     = 1'b0;
               busy_n  = 1'b0;
               rem_n   = '0;
               pulse_n = '0;
            end else if (Remaining == CNT_W'(1)) begin
               done_n  = last_pulse;
               pulse_n = last_pulse ? '0 : pulse_cnt + BURST_W'(1);
               if (off_lat != '0) begin
                  state_n = COOL;
                  x_n     = 1'b0;
                  rem_n   = off_lat;
               end else if (!last_pulse || (Mode && B)) begin
                  rem_n = on_lat;
               end else begin
                  state_n = IDLE;
                  x_n     = 1'b0;
                  busy_n  = 1'b0;
                  rem_n   = '0;
               end
            end else if (Remaining != '0) begin
               rem_n = Remaining - CNT_W'(1);
            end
         end
         COOL: begin
            if (Abort) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               rem_n   = '0;
               pulse_n = '0;
            end else if (Remaining == CNT_W'(1)) begin
               if (more_pulses || (Mode && B)) begin
                  state_n = ON;
                  x_n     = 1'b1;
                  rem_n   = on_lat;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  rem_n   = '0;
               end
            end else if (Remaining != '0) begin
               rem_n = Remaining - CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            x_n     = 1'b0;
            busy_n  = 1'b0;
            rem_n   = '0;
            pulse_n = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_laser_pulse_ctrl.sv
// tb/tb_laser_pulse_ctrl.sv - directed scoreboard bench for laser_pulse_ctrl
// Burst checks included when LASER_BURST_EN is defined.
module tb_laser_pulse_ctrl;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        B = 1'b0;
   logic        Abort = 1'b0;
   logic        Mode = 1'b0;
   logic [15:0] OnTime = '0;
   logic [15:0] OffTime = '0;
   logic [3:0]  BurstCnt = 4'd1;
   logic        X, Busy, Done;
   logic [15:0] Remaining;

   int tests = 0;
   int fails = 0;

   logic [18:0] exp_q[$];
   string       tag_q[$];

   always #5 Clk = ~Clk;

   laser_pulse_ctrl #(.CNT_W(16), .BURST_W(4)) dut (
      .Clk(Clk),
      .Rst(Rst),
      .B(B),
      .Abort(Abort),
      .Mode(Mode),
      .OnTime(OnTime),
      .OffTime(OffTime),
`ifdef LASER_BURST_EN
      .BurstCnt(BurstCnt),
`endif
      .X(X),
      .Busy(Busy),
      .Done(Done),
      .Remaining(Remaining)
   );

   // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
   task automatic step(input logic r, input logic b, input logic ab,
                       input logic ex, input logic eb, input logic ed,
                       input logic [15:0] er, input string tag);
      logic [18:0] obs, e;
      string t;
      @(negedge Clk);
      Rst = r;
      B = b;
      Abort = ab;
      exp_q.push_back({ex, eb, ed, er});
      tag_q.push_back(tag);
      @(posedge Clk);
      #1;
      obs = {X, Busy, Done, Remaining};
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      tests++;
      assert (obs === e) else begin
         fails++;
         $error("FAIL %s observed x/busy/done/rem=%b/%b/%b/%0d expected=%b/%b/%b/%0d",
                t, obs[18], obs[17], obs[16], obs[15:0], e[18], e[17], e[16], e[15:0]);
      end
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0, 0, "reset0");
      step(1, 1, 0, 0, 0, 0, 0, "reset1");
      step(0, 0, 0, 0, 0, 0, 0, "idle");

      // single shot 5 on / 3 off
      OnTime = 16'd5; OffTime = 16'd3; Mode = 1'b0;
      step(0, 1, 0, 1, 1, 0, 5, "ss_on5");
      for (int i = 4; i >= 1; i--) step(0, 0, 0, 1, 1, 0, 16'(i), "ss_on");
      step(0, 0, 0, 0, 1, 1, 3, "ss_cool3_done");
      step(0, 0, 0, 0, 1, 0, 2, "ss_cool2");
      step(0, 0, 0, 0, 1, 0, 1, "ss_cool1");
      step(0, 0, 0, 0, 0, 0, 0, "ss_idle");

      // B held 20 cycles: one pulse only
      OnTime = 16'd4; OffTime = 16'd2;
      for (int i = 0; i < 20; i++) begin
         if (i < 4)       step(0, 1, 0, 1, 1, 0, 16'(4 - i), "hold_on");
         else if (i == 4) step(0, 1, 0, 0, 1, 1, 2, "hold_cool_done");
         else if (i == 5) step(0, 1, 0, 0, 1, 0, 1, "hold_cool1");
         else             step(0, 1, 0, 0, 0, 0, 0, "hold_idle");
      end
      step(0, 0, 0, 0, 0, 0, 0, "hold_release");
      // B edge during COOL is ignored
      step(0, 1, 0, 1, 1, 0, 4, "lock_on4");
      step(0, 0, 0, 1, 1, 0, 3, "lock_on3");
      step(0, 0, 0, 1, 1, 0, 2, "lock_on2");
      step(0, 0, 0, 1, 1, 0, 1, "lock_on1");
      step(0, 0, 0, 0, 1, 1, 2, "lock_cool2");
      step(0, 1, 0, 0, 1, 0, 1, "lock_edge_in_cool");
      step(0, 0, 0, 0, 0, 0, 0, "lock_idle");
      step(0, 0, 0, 0, 0, 0, 0, "lock_idle2");

      // auto-repeat 3 on / 2 off while B held
      Mode = 1'b1; OnTime = 16'd3; OffTime = 16'd2;
      for (int k = 0; k < 2; k++) begin
         step(0, 1, 0, 1, 1, 0, 3, "rep_on3");
         step(0, 1, 0, 1, 1, 0, 2, "rep_on2");
         step(0, 1, 0, 1, 1, 0, 1, "rep_on1");
         step(0, 1, 0, 0, 1, 1, 2, "rep_cool2");
         if (k == 0) step(0, 1, 0, 0, 1, 0, 1, "rep_cool1");
         else        step(0, 0, 0, 0, 1, 0, 1, "rep_cool1_last");
      end
      step(0, 0, 0, 0, 0, 0, 0, "rep_idle");
      Mode = 1'b0;

      // abort on second ON cycle
      OnTime = 16'd10; OffTime = 16'd3;
      step(0, 1, 0, 1, 1, 0, 10, "ab_on10");
      step(0, 0, 0, 1, 1, 0, 9, "ab_on9");
      step(0, 0, 1, 0, 0, 0, 0, "ab_idle");
      step(0, 0, 0, 0, 0, 0, 0, "ab_no_done");
      // abort with start edge in IDLE
      step(0, 1, 1, 0, 0, 0, 0, "ab_block_start");
      step(0, 1, 0, 0, 0, 0, 0, "ab_held_no_start");
      step(0, 0, 0, 0, 0, 0, 0, "ab_idle2");

      // zero times: one-cycle pulse, COOL skipped
      OnTime = 16'd0; OffTime = 16'd0;
      step(0, 1, 0, 1, 1, 0, 1, "zero_on");
      step(0, 0, 0, 0, 0, 1, 0, "zero_done_idle");
      step(0, 0, 0, 0, 0, 0, 0, "zero_idle");

      // reset mid-ON
      OnTime = 16'd5; OffTime = 16'd3;
      step(0, 1, 0, 1, 1, 0, 5, "rst_on5");
      step(0, 0, 0, 1, 1, 0, 4, "rst_on4");
      step(1, 0, 0, 0, 0, 0, 0, "rst_mid_on");
      step(0, 0, 0, 0, 0, 0, 0, "rst_idle");

`ifdef LASER_BURST_EN
      // burst of 3: 11 0 11 0 11, single Done
      BurstCnt = 4'd3; OnTime = 16'd2; OffTime = 16'd1;
      step(0, 1, 0, 1, 1, 0, 2, "burst_p1_on2");
      step(0, 0, 0, 1, 1, 0, 1, "burst_p1_on1");
      step(0, 0, 0, 0, 1, 0, 1, "burst_p1_cool");
      step(0, 0, 0, 1, 1, 0, 2, "burst_p2_on2");
      step(0, 0, 0, 1, 1, 0, 1, "burst_p2_on1");
      step(0, 0, 0, 0, 1, 0, 1, "burst_p2_cool");
      step(0, 0, 0, 1, 1, 0, 2, "burst_p3_on2");
      step(0, 0, 0, 1, 1, 0, 1, "burst_p3_on1");
      step(0, 0, 0, 0, 1, 1, 1, "burst_done");
      step(0, 0, 0, 0, 0, 0, 0, "burst_idle");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/laser_pulse_ctrl.md
Name: laser_pulse_ctrl

Overview:
Parametrised laser pulse controller. It is the successor to the fixed-count laser on/off state machine, and it integrates its own countdown timer. It produces a laser-enable pulse of programmable length on a rising edge of the start button, followed by a programmable cool-down lockout. It supports single-shot and auto-repeat modes and an abort input. It sits between the debounced front-panel button and the laser driver output pin.

Parameters:
CNT_W, 16, width of the on-time, off-time and internal countdown counter
BURST_W, 4, width of the burst count (used only with LASER_BURST_EN)

Ports:
Clk  in  1  system clock, all logic on posedge
Rst  in  1  reset Rst, synchronous, active-high; clock Clk
B  in  1  start button (already debounced, synchronous to Clk)
Abort  in  1  synchronous abort, active-high, level
Mode  in  1  0 = single-shot, 1 = auto-repeat while B held
OnTime  in  CNT_W  laser-on length in Clk cycles, latched at start
OffTime  in  CNT_W  cool-down length in Clk cycles, latched at start
X  out  1  laser enable
Busy  out  1  high in any state other than IDLE
Done  out  1  one-cycle pulse at normal end of a pulse (or burst)
Remaining  out  CNT_W  current countdown value; 0 in IDLE
BurstCnt  in  BURST_W  pulses per trigger (port present only with LASER_BURST_EN)

Behaviour:
- All outputs are registered (Moore). The edge detector uses register Bq, which holds B delayed one cycle.
- Reset values: State=IDLE, X=0, Busy=0, Done=0, Remaining=0, Bq=0. Reset has priority over all other inputs, including mid-pulse; X drops the cycle after the reset edge.
- Start event: B=1 and Bq=0 sampled at the same posedge. A held B does not retrigger in single-shot mode.
- States: IDLE, ON, COOL.
- IDLE -> ON on a start event with Abort=0:
  - OnTime and OffTime are latched; Remaining is loaded with the latched OnTime.
  - X=1 beginning the cycle after the start edge.
  - OnTime=0 is treated as 1.
- ON:
  - X=1, and Remaining decrements by 1 per cycle.
  - X stays high for exactly max(OnTime,1) cycles.
  - When Remaining==1 at the posedge, the block goes to COOL with Remaining = latched OffTime and Done=1 for that one cycle.
  - If the latched OffTime==0, COOL is skipped: the block goes straight to IDLE, or to ON under the repeat rule below.
- COOL:
  - X=0, Remaining decrements, and B start events are ignored (lockout).
  - When Remaining==1: if Mode=1 and B==1, reload the latched OnTime and go to ON. Otherwise go to IDLE.
- Abort=1 in ON or COOL: the next state is IDLE, X=0 the following cycle, Remaining=0, and no Done pulse. Abort in IDLE blocks a start event in the same cycle.
- Start event and Abort in the same cycle: Abort wins.
- Counters never wrap: the decrement happens only when Remaining>0.
- Mode is sampled only at the COOL exit decision, so changing it mid-pulse has no effect on the current pulse.

Optional Feature:
Macro LASER_BURST_EN.
- Defined: port BurstCnt exists and is latched at start, with 0 treated as 1. An internal pulse counter counts completed ON phases. COOL exits back to ON until BurstCnt pulses have completed, regardless of B and Mode. Done pulses only at the end of the last ON phase of the burst. Auto-repeat (Mode=1) re-arms a whole new burst.
- Not defined: the port is absent, each trigger produces one ON phase, and Done pulses at the end of every ON phase.

Test Plan:
- Reset, then single B edge with OnTime=5, OffTime=3, Mode=0 -> X high exactly 5 cycles starting 1 cycle after the edge; Done=1 on the cycle X falls; Busy low 3 cycles later; Remaining counts 5..1, then 3..1, then 0.
- B held high 20 cycles, Mode=0, OnTime=4, OffTime=2 -> exactly one 4-cycle X pulse; B edges during COOL produce no pulse.
- Mode=1, B held, OnTime=3, OffTime=2 -> repeating X pattern of 3 high, 2 low until B drops; when B is low at COOL exit, the block returns to IDLE.
- Abort asserted on the 2nd ON cycle with OnTime=10 -> X low the next cycle, Busy=0, Remaining=0, no Done pulse; Abort together with a start edge in IDLE -> no pulse.
- OnTime=0, OffTime=0 -> 1-cycle X pulse, Done=1, immediate return to IDLE; Rst asserted mid-ON -> X=0 and State=IDLE one cycle later.
- With LASER_BURST_EN, BurstCnt=3, OnTime=2, OffTime=1 -> X pattern 11 0 11 0 11, with a single Done pulse on the final fall.
